// File: rtl/rs_alu_station.sv
// ALU reservation station: holds issued ops until operands arrive,
// snoops both result buses and dispatches one ready op per cycle.
module rs_alu_station #(
  parameter int RS_SIZE      = 16,
  parameter int RS_SIZE_LOG  = 4,
  parameter int ROB_SIZE_LOG = 4,
  parameter int OP_SIZE_LOG  = 6,
  parameter int OP_NOP       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    jump_rst,
  input  logic                    issue_valid,
  input  logic [OP_SIZE_LOG-1:0]  issue_op,
  input  logic [31:0]             issue_Vj,
  input  logic [31:0]             issue_Vk,
  input  logic [ROB_SIZE_LOG-1:0] issue_Qj,
  input  logic [ROB_SIZE_LOG-1:0] issue_Qk,
  input  logic                    issue_Rj,
  input  logic                    issue_Rk,
  input  logic [31:0]             issue_imm,
  input  logic [ROB_SIZE_LOG-1:0] issue_reorder,
  input  logic [31:0]             issue_pc,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] alu_cdb_reorder,
  input  logic [31:0]             alu_cdb_val,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_reorder,
  input  logic [31:0]             lsb_cdb_val,
  output logic                    full,
  output logic                    RS_valid,
  output logic [OP_SIZE_LOG-1:0]  op,
  output logic [31:0]             Vj,
  output logic [31:0]             Vk,
  output logic [31:0]             imm,
  output logic [ROB_SIZE_LOG-1:0] RS_reorder,
  output logic [31:0]             curPC
);

  typedef struct packed {
    logic                    busy;
    logic [OP_SIZE_LOG-1:0]  op;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic [ROB_SIZE_LOG-1:0] qj;
    logic [ROB_SIZE_LOG-1:0] qk;
    logic                    rj;
    logic                    rk;
    logic [31:0]             imm;
    logic [ROB_SIZE_LOG-1:0] rob;
    logic [31:0]             pc;
  } ent_t;

  localparam logic [OP_SIZE_LOG-1:0] NOP = OP_SIZE_LOG'(OP_NOP);

  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];

  logic                    vld_q, vld_d;
  logic [OP_SIZE_LOG-1:0]  op_q, op_d;
  logic [31:0]             vj_q, vj_d;
  logic [31:0]             vk_q, vk_d;
  logic [31:0]             imm_q, imm_d;
  logic [ROB_SIZE_LOG-1:0] rob_q, rob_d;
  logic [31:0]             pc_q, pc_d;

  logic [RS_SIZE-1:0]     busy;
  logic                   sel_found;
  logic [RS_SIZE_LOG-1:0] sel_idx;
  logic                   free_found;
  logic [RS_SIZE_LOG-1:0] free_idx;

  // ALU bus takes precedence when both buses carry the same tag
  function automatic logic [32:0] snoop(
    input logic [ROB_SIZE_LOG-1:0] tag
  );
    logic [32:0] r;
    r = '0;
    if (lsb_cdb_valid && lsb_cdb_reorder == tag)
      r = {1'b1, lsb_cdb_val};
    if (alu_cdb_valid && alu_cdb_reorder == tag)
      r = {1'b1, alu_cdb_val};
    return r;
  endfunction

  always_comb begin
    busy       = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy[i] = ent_q[i].busy;
      if (ent_q[i].busy && ent_q[i].rj && ent_q[i].rk) begin
        sel_found = 1'b1;
        sel_idx   = RS_SIZE_LOG'(i);
      end
      if (!ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = RS_SIZE_LOG'(i);
      end
    end
  end

  assign full = &busy;

  always_comb begin
    logic [32:0] fj;
    logic [32:0] fk;
    ent_d = ent_q;
    vld_d = vld_q;
    op_d  = op_q;
    vj_d  = vj_q;
    vk_d  = vk_q;
    imm_d = imm_q;
    rob_d = rob_q;
    pc_d  = pc_q;
    fj    = '0;
    fk    = '0;
    if (rdy) begin
      if (jump_rst) begin
        for (int i = 0; i < RS_SIZE; i++)
          ent_d[i].busy = 1'b0;
        vld_d = 1'b0;
        op_d  = NOP;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy && !ent_q[i].rj) begin
            fj = snoop(ent_q[i].qj);
            if (fj[32]) begin
              ent_d[i].vj = fj[31:0];
              ent_d[i].rj = 1'b1;
            end
          end
          if (ent_q[i].busy && !ent_q[i].rk) begin
            fk = snoop(ent_q[i].qk);
            if (fk[32]) begin
              ent_d[i].vk = fk[31:0];
              ent_d[i].rk = 1'b1;
            end
          end
        end
        if (sel_found) begin
          vld_d = 1'b1;
          op_d  = ent_q[sel_idx].op;
          vj_d  = ent_q[sel_idx].vj;
          vk_d  = ent_q[sel_idx].vk;
          imm_d = ent_q[sel_idx].imm;
          rob_d = ent_q[sel_idx].rob;
          pc_d  = ent_q[sel_idx].pc;
          ent_d[sel_idx].busy = 1'b0;
        end else begin
          vld_d = 1'b0;
          op_d  = NOP;
        end
        // slot chosen from pre-edge state, so it never collides with dispatch
        if (issue_valid && !full && free_found) begin
          fj = snoop(issue_Qj);
          fk = snoop(issue_Qk);
          ent_d[free_idx].busy = 1'b1;
          ent_d[free_idx].op   = issue_op;
          ent_d[free_idx].qj   = issue_Qj;
          ent_d[free_idx].qk   = issue_Qk;
          ent_d[free_idx].imm  = issue_imm;
          ent_d[free_idx].rob  = issue_reorder;
          ent_d[free_idx].pc   = issue_pc;
          ent_d[free_idx].rj   = issue_Rj || fj[32];
          ent_d[free_idx].rk   = issue_Rk || fk[32];
          ent_d[free_idx].vj   =
            (!issue_Rj && fj[32]) ? fj[31:0] : issue_Vj;
          ent_d[free_idx].vk   =
            (!issue_Rk && fk[32]) ? fk[31:0] : issue_Vk;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++)
        ent_q[i] <= '0;
      vld_q <= 1'b0;
      op_q  <= NOP;
      vj_q  <= '0;
      vk_q  <= '0;
      imm_q <= '0;
      rob_q <= '0;
      pc_q  <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++)
        ent_q[i] <= ent_d[i];
      vld_q <= vld_d;
      op_q  <= op_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
      imm_q <= imm_d;
      rob_q <= rob_d;
      pc_q  <= pc_d;
    end
  end

  assign RS_valid   = vld_q;
  assign op         = op_q;
  assign Vj         = vj_q;
  assign Vk         = vk_q;
  assign imm        = imm_q;
  assign RS_reorder = rob_q;
  assign curPC      = pc_q;

endmodule

// File: tb/tb_rs_alu_station.sv
// Directed bench for rs_alu_station: issue, wakeup, forwarding,
// ordering, flush, freeze and asynchronous reset.
module tb_rs_alu_station;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_rst;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_Vj, issue_Vk;
  logic [3:0]  issue_Qj, issue_Qk;
  logic        issue_Rj, issue_Rk;
  logic [31:0] issue_imm;
  logic [3:0]  issue_reorder;
  logic [31:0] issue_pc;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_reorder, lsb_cdb_reorder;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        full;
  logic        RS_valid;
  logic [5:0]  op;
  logic [31:0] Vj, Vk, imm;
  logic [3:0]  RS_reorder;
  logic [31:0] curPC;

  int n_tests;
  int n_fail;

  rs_alu_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
    .issue_imm(issue_imm), .issue_reorder(issue_reorder),
    .issue_pc(issue_pc),
    .alu_cdb_valid(alu_cdb_valid),
    .alu_cdb_reorder(alu_cdb_reorder),
    .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_reorder(lsb_cdb_reorder),
    .lsb_cdb_val(lsb_cdb_val),
    .full(full), .RS_valid(RS_valid), .op(op),
    .Vj(Vj), .Vk(Vk), .imm(imm),
    .RS_reorder(RS_reorder), .curPC(curPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_op        = '0;
    issue_Vj        = '0;
    issue_Vk        = '0;
    issue_Qj        = '0;
    issue_Qk        = '0;
    issue_Rj        = 1'b0;
    issue_Rk        = 1'b0;
    issue_imm       = '0;
    issue_reorder   = '0;
    issue_pc        = '0;
    alu_cdb_valid   = 1'b0;
    alu_cdb_reorder = '0;
    alu_cdb_val     = '0;
    lsb_cdb_valid   = 1'b0;
    lsb_cdb_reorder = '0;
    lsb_cdb_val     = '0;
  endtask

  task automatic put(
    input logic [5:0] o, input logic [31:0] vj,
    input logic [31:0] vk, input logic [3:0] qj,
    input logic [3:0] qk, input logic rj, input logic rk,
    input logic [31:0] im, input logic [3:0] rob,
    input logic [31:0] pc
  );
    issue_valid   = 1'b1;
    issue_op      = o;
    issue_Vj      = vj;
    issue_Vk      = vk;
    issue_Qj      = qj;
    issue_Qk      = qk;
    issue_Rj      = rj;
    issue_Rk      = rk;
    issue_imm     = im;
    issue_reorder = rob;
    issue_pc      = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    jump_rst = 1'b0;
    idle();
    #2;
    n_tests++;
    if (RS_valid !== 1'b0 || op !== 6'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs got v=%0b op=%0d full=%0b need 0/0/0",
               RS_valid, op, full);
    end
    n_tests++;
    if (Vj !== 0 || Vk !== 0 || imm !== 0 || curPC !== 0 ||
        RS_reorder !== 0) begin
      n_fail++;
      $display("FAIL reset_data got Vj=%h Vk=%h imm=%h pc=%h rob=%0d need 0",
               Vj, Vk, imm, curPC, RS_reorder);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ready_issue();
    put(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1,
        32'd0, 4'd3, 32'h100);
    tick();
    idle();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_early got v=%0b need 0", RS_valid);
    end
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || Vj !== 32'd5 || Vk !== 32'd7 ||
        RS_reorder !== 4'd3 || op !== 6'd1 || curPC !== 32'h100) begin
      n_fail++;
      $display("FAIL ready_disp got v=%0b Vj=%0d Vk=%0d rob=%0d op=%0d pc=%h need 1/5/7/3/1/100",
               RS_valid, Vj, Vk, RS_reorder, op, curPC);
    end
    tick();
    n_tests++;
    if (RS_valid !== 1'b0 || op !== 6'd0) begin
      n_fail++;
      $display("FAIL ready_after got v=%0b op=%0d need 0/0", RS_valid, op);
    end
  endtask

  task automatic test_wakeup();
    put(6'd2, 32'd0, 32'd0, 4'd6, 4'd0, 1'b0, 1'b1,
        32'd10, 4'd4, 32'h200);
    tick();
    idle();
    tick();
    tick();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_wait got v=%0b need 0", RS_valid);
    end
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd6;
    alu_cdb_val     = 32'h20;
    tick();
    idle();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_comb got v=%0b need 0", RS_valid);
    end
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || Vj !== 32'h20 || imm !== 32'd10 ||
        RS_reorder !== 4'd4) begin
      n_fail++;
      $display("FAIL wake_disp got v=%0b Vj=%h imm=%0d rob=%0d need 1/20/10/4",
               RS_valid, Vj, imm, RS_reorder);
    end
    tick();
  endtask

  task automatic test_forward();
    put(6'd3, 32'd1, 32'd0, 4'd0, 4'd2, 1'b1, 1'b0,
        32'd0, 4'd8, 32'h300);
    lsb_cdb_valid   = 1'b1;
    lsb_cdb_reorder = 4'd2;
    lsb_cdb_val     = 32'hFFFF_FFFF;
    tick();
    idle();
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || Vk !== 32'hFFFF_FFFF ||
        RS_reorder !== 4'd8) begin
      n_fail++;
      $display("FAIL fwd_lsb got v=%0b Vk=%h rob=%0d need 1/ffffffff/8",
               RS_valid, Vk, RS_reorder);
    end
    put(6'd3, 32'd0, 32'd9, 4'd5, 4'd0, 1'b0, 1'b1,
        32'd0, 4'd9, 32'h304);
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd5;
    alu_cdb_val     = 32'h11;
    lsb_cdb_valid   = 1'b1;
    lsb_cdb_reorder = 4'd5;
    lsb_cdb_val     = 32'h22;
    tick();
    idle();
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || Vj !== 32'h11 || RS_reorder !== 4'd9) begin
      n_fail++;
      $display("FAIL fwd_alu_wins got v=%0b Vj=%h rob=%0d need 1/11/9",
               RS_valid, Vj, RS_reorder);
    end
    tick();
  endtask

  task automatic test_full_order();
    for (int i = 0; i < 16; i++) begin
      put(6'd4, 32'd0, 32'd0, (i == 4 || i == 9) ? 4'd7 : 4'd1,
          4'd0, 1'b0, 1'b1, 32'd0, 4'(i), 32'(i * 4));
      tick();
    end
    n_tests++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_set got %0b need 1", full);
    end
    put(6'd5, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1,
        32'd0, 4'd15, 32'h500);
    tick();
    idle();
    tick();
    n_tests++;
    if (RS_valid !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ignore got v=%0b full=%0b need 0/1",
               RS_valid, full);
    end
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd7;
    alu_cdb_val     = 32'h77;
    tick();
    idle();
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || RS_reorder !== 4'd4 || Vj !== 32'h77 ||
        full !== 1'b0) begin
      n_fail++;
      $display("FAIL order_first got v=%0b rob=%0d Vj=%h full=%0b need 1/4/77/0",
               RS_valid, RS_reorder, Vj, full);
    end
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || RS_reorder !== 4'd9 ||
        curPC !== 32'd36) begin
      n_fail++;
      $display("FAIL order_second got v=%0b rob=%0d pc=%0d need 1/9/36",
               RS_valid, RS_reorder, curPC);
    end
    tick();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_done got v=%0b need 0", RS_valid);
    end
  endtask

  task automatic test_flush();
    jump_rst = 1'b1;
    put(6'd6, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1,
        32'd0, 4'd12, 32'h600);
    tick();
    jump_rst = 1'b0;
    idle();
    n_tests++;
    if (RS_valid !== 1'b0 || op !== 6'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_outs got v=%0b op=%0d full=%0b need 0/0/0",
               RS_valid, op, full);
    end
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd1;
    alu_cdb_val     = 32'h1;
    tick();
    idle();
    tick();
    tick();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty got v=%0b rob=%0d need 0",
               RS_valid, RS_reorder);
    end
  endtask

  task automatic test_freeze();
    put(6'd7, 32'hAA, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1,
        32'd0, 4'd5, 32'h700);
    tick();
    put(6'd8, 32'd0, 32'd0, 4'd3, 4'd0, 1'b0, 1'b1,
        32'd0, 4'd6, 32'h704);
    tick();
    rdy = 1'b0;
    idle();
    put(6'd9, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1,
        32'd0, 4'd7, 32'h708);
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd3;
    alu_cdb_val     = 32'h33;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (RS_valid !== 1'b1 || RS_reorder !== 4'd5 ||
          Vj !== 32'hAA || op !== 6'd7) begin
        n_fail++;
        $display("FAIL freeze_hold%0d got v=%0b rob=%0d Vj=%h op=%0d need 1/5/aa/7",
                 c, RS_valid, RS_reorder, Vj, op);
      end
    end
    rdy = 1'b1;
    idle();
    tick();
    tick();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_nocap got v=%0b rob=%0d need 0",
               RS_valid, RS_reorder);
    end
    alu_cdb_valid   = 1'b1;
    alu_cdb_reorder = 4'd3;
    alu_cdb_val     = 32'h33;
    tick();
    idle();
    tick();
    n_tests++;
    if (RS_valid !== 1'b1 || RS_reorder !== 4'd6 || Vj !== 32'h33) begin
      n_fail++;
      $display("FAIL freeze_resume got v=%0b rob=%0d Vj=%h need 1/6/33",
               RS_valid, RS_reorder, Vj);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      put(6'd10, 32'(i), 32'd0, 4'd0, 4'd0, 1'b1, 1'b1,
          32'd0, 4'(i), 32'h800);
      tick();
    end
    idle();
    n_tests++;
    if (RS_valid !== 1'b1 || RS_reorder !== 4'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre got v=%0b rob=%0d need 1/2",
               RS_valid, RS_reorder);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (RS_valid !== 1'b0 || op !== 6'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%0b op=%0d full=%0b need 0/0/0",
               RS_valid, op, full);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (RS_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after got v=%0b rob=%0d need 0",
               RS_valid, RS_reorder);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_forward();
    test_full_order();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
